id_ex_stage: RTL and testbench

ID/EX pipeline stage of the MIPS pipeline, directly upstream of the execution ALU. Each cycle it captures the decoded instruction from ID and drives the ALU's operands `A`/`B` and 3-bit `control`. Operands are forwarded from EX/MEM and MEM/WB. The stage inserts a bubble on a load-use hazard and honours the pipeline-wide stall and flush. Register-side outputs (write register, store data, memory controls) go on to the EX/MEM register.

---
 rtl/mips_pkg.sv | 71 +++++++
 rtl/id_ex_stage_if.sv | 64 ++++++
 rtl/alu_control_decoder.sv | 32 +++
 rtl/id_ex_stage.sv | 94 +++++++++
 tb/tb_id_ex_stage.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: ALU control codes, ALU-op encodings,
// funct constants, the ID/EX register record and the forwarding helper.
package mips_pkg;

   localparam int DATA_W = 32;
   localparam int REG_W  = 5;

   // ALU control codes driven to the execution ALU
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;

   // Main-decoder ALU operation classes
   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_RTYPE = 2'b10,
      ALUOP_RSVD  = 2'b11
   } alu_op_e;

   // R-type funct fields understood by this pipeline
   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;

   // Contents of the ID/EX pipeline register
   typedef struct packed {
      logic              valid;
      logic              reg_write;
      logic              mem_read;
      logic              mem_write;
      logic              mem_to_reg;
      logic              alu_src;
      logic [2:0]        alu_control;
      logic              illegal;
      logic [REG_W-1:0]  rs;
      logic [REG_W-1:0]  rt;
      logic [REG_W-1:0]  write_reg;
      logic [DATA_W-1:0] rs_data;
      logic [DATA_W-1:0] rt_data;
      logic [DATA_W-1:0] imm;
   } ex_state_t;

   // A bubble: nothing valid, no side effects, ALU set to a harmless add
   function automatic ex_state_t bubble_state();
      ex_state_t s;
      s             = '0;
      s.alu_control = ALU_ADD;
      return s;
   endfunction

   // Pick the freshest value of register idx; r0 always reads the file data
   function automatic logic [DATA_W-1:0] forward_operand(
      input logic [REG_W-1:0]  idx,
      input logic [DATA_W-1:0] reg_data,
      input logic              exmem_we,
      input logic [REG_W-1:0]  exmem_rd,
      input logic [DATA_W-1:0] exmem_res,
      input logic              memwb_we,
      input logic [REG_W-1:0]  memwb_rd,
      input logic [DATA_W-1:0] memwb_res);
      if (idx != '0 && exmem_we && exmem_rd == idx)
         return exmem_res;
      else if (idx != '0 && memwb_we && memwb_rd == idx)
         return memwb_res;
      return reg_data;
   endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle of the ID-side, forwarding and EX-side signals around the ID/EX stage.
// master drives ID and forwarding sources; slave is the stage itself.
interface id_ex_stage_if;

   logic                       stall;
   logic                       flush;
   logic                       id_valid;
   logic                       id_reg_write;
   logic                       id_mem_read;
   logic                       id_mem_write;
   logic                       id_mem_to_reg;
   logic                       id_alu_src;
   logic                       id_reg_dst;
   logic [1:0]                 id_alu_op;
   logic [5:0]                 id_funct;
   logic [mips_pkg::REG_W-1:0]  id_rs;
   logic [mips_pkg::REG_W-1:0]  id_rt;
   logic [mips_pkg::REG_W-1:0]  id_rd;
   logic [mips_pkg::DATA_W-1:0] id_rs_data;
   logic [mips_pkg::DATA_W-1:0] id_rt_data;
   logic [mips_pkg::DATA_W-1:0] id_imm;
   logic                       exmem_reg_write;
   logic [mips_pkg::REG_W-1:0]  exmem_rd;
   logic [mips_pkg::DATA_W-1:0] exmem_result;
   logic                       memwb_reg_write;
   logic [mips_pkg::REG_W-1:0]  memwb_rd;
   logic [mips_pkg::DATA_W-1:0] memwb_result;

   logic [mips_pkg::DATA_W-1:0] alu_a;
   logic [mips_pkg::DATA_W-1:0] alu_b;
   logic [2:0]                 alu_control;
   logic                       ex_valid;
   logic                       ex_reg_write;
   logic                       ex_mem_read;
   logic                       ex_mem_write;
   logic                       ex_mem_to_reg;
   logic [mips_pkg::REG_W-1:0]  ex_write_reg;
   logic [mips_pkg::DATA_W-1:0] ex_store_data;
   logic                       ex_illegal;
   logic                       hazard_stall;

   modport master (
      output stall, flush, id_valid, id_reg_write, id_mem_read, id_mem_write,
             id_mem_to_reg, id_alu_src, id_reg_dst, id_alu_op, id_funct,
             id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm,
             exmem_reg_write, exmem_rd, exmem_result,
             memwb_reg_write, memwb_rd, memwb_result,
      input  alu_a, alu_b, alu_control, ex_valid, ex_reg_write, ex_mem_read,
             ex_mem_write, ex_mem_to_reg, ex_write_reg, ex_store_data,
             ex_illegal, hazard_stall
   );

   modport slave (
      input  stall, flush, id_valid, id_reg_write, id_mem_read, id_mem_write,
             id_mem_to_reg, id_alu_src, id_reg_dst, id_alu_op, id_funct,
             id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm,
             exmem_reg_write, exmem_rd, exmem_result,
             memwb_reg_write, memwb_rd, memwb_result,
      output alu_a, alu_b, alu_control, ex_valid, ex_reg_write, ex_mem_read,
             ex_mem_write, ex_mem_to_reg, ex_write_reg, ex_store_data,
             ex_illegal, hazard_stall
   );

endinterface

// File: rtl/alu_control_decoder.sv
// Maps the main-decoder ALU op plus funct onto a 3-bit ALU control code.
// Unsupported combinations fall back to add and raise illegal.
module alu_control_decoder
   import mips_pkg::*;
(
   input  logic [1:0] alu_op_i,
   input  logic [5:0] funct_i,
   output logic [2:0] alu_control_o,
   output logic       illegal_o
);

   // Combinational decode of op class and funct
   always_comb begin
      alu_control_o = ALU_ADD;
      illegal_o     = 1'b0;
      case (alu_op_i)
         ALUOP_ADD: alu_control_o = ALU_ADD;
         ALUOP_SUB: alu_control_o = ALU_SUB;
         ALUOP_RTYPE: begin
            case (funct_i)
               FUNCT_ADD: alu_control_o = ALU_ADD;
               FUNCT_SUB: alu_control_o = ALU_SUB;
               FUNCT_AND: alu_control_o = ALU_AND;
               FUNCT_OR:  alu_control_o = ALU_OR;
               default:   illegal_o     = 1'b1;
            endcase
         end
         default: illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU: captures decoded instructions,
// forwards operands from EX/MEM and MEM/WB, detects load-use hazards and
// applies flush > stall > hazard bubble > capture at every edge.
module id_ex_stage
   import mips_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   id_ex_stage_if.slave bus
);

   ex_state_t   ex_q;
   ex_state_t   ex_d;
   ex_state_t   capture_d;
   logic [2:0]  dec_control;
   logic        dec_illegal;
   logic [DATA_W-1:0] fwd_rs;
   logic [DATA_W-1:0] fwd_rt;
   logic        hazard;

   alu_control_decoder u_alu_dec (
      .alu_op_i      (bus.id_alu_op),
      .funct_i       (bus.id_funct),
      .alu_control_o (dec_control),
      .illegal_o     (dec_illegal)
   );

   // Load-use: the load in EX writes a register the instruction in ID reads
   assign hazard = bus.id_valid & ex_q.valid & ex_q.mem_read &
                   (ex_q.write_reg != '0) &
                   ((ex_q.write_reg == bus.id_rs) | (ex_q.write_reg == bus.id_rt));

   // Register image of the instruction currently held in ID
   always_comb begin
      capture_d             = '0;
      capture_d.valid       = 1'b1;
      capture_d.reg_write   = bus.id_reg_write;
      capture_d.mem_read    = bus.id_mem_read;
      capture_d.mem_write   = bus.id_mem_write;
      capture_d.mem_to_reg  = bus.id_mem_to_reg;
      capture_d.alu_src     = bus.id_alu_src;
      capture_d.alu_control = dec_control;
      capture_d.illegal     = dec_illegal;
      capture_d.rs          = bus.id_rs;
      capture_d.rt          = bus.id_rt;
      capture_d.write_reg   = bus.id_reg_dst ? bus.id_rd : bus.id_rt;
      capture_d.rs_data     = bus.id_rs_data;
      capture_d.rt_data     = bus.id_rt_data;
      capture_d.imm         = bus.id_imm;
   end

   // Next-state selection; an invalid ID slot is captured as a bubble
   always_comb begin
      ex_d = ex_q;
      if (bus.flush)
         ex_d = bubble_state();
      else if (!bus.stall) begin
         if (hazard || !bus.id_valid)
            ex_d = bubble_state();
         else
            ex_d = capture_d;
      end
   end

   // Pipeline register with asynchronous clear to a bubble
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         ex_q <= bubble_state();
      else
         ex_q <= ex_d;
   end

   // Forwarded operands, recomputed each cycle from the live bypass sources
   assign fwd_rs = forward_operand(ex_q.rs, ex_q.rs_data,
                                   bus.exmem_reg_write, bus.exmem_rd, bus.exmem_result,
                                   bus.memwb_reg_write, bus.memwb_rd, bus.memwb_result);
   assign fwd_rt = forward_operand(ex_q.rt, ex_q.rt_data,
                                   bus.exmem_reg_write, bus.exmem_rd, bus.exmem_result,
                                   bus.memwb_reg_write, bus.memwb_rd, bus.memwb_result);

   assign bus.alu_a         = fwd_rs;
   assign bus.alu_b         = ex_q.alu_src ? ex_q.imm : fwd_rt;
   assign bus.ex_store_data = fwd_rt;
   assign bus.alu_control   = ex_q.alu_control;
   assign bus.ex_valid      = ex_q.valid;
   assign bus.ex_reg_write  = ex_q.reg_write;
   assign bus.ex_mem_read   = ex_q.mem_read;
   assign bus.ex_mem_write  = ex_q.mem_write;
   assign bus.ex_mem_to_reg = ex_q.mem_to_reg;
   assign bus.ex_write_reg  = ex_q.write_reg;
   assign bus.ex_illegal    = ex_q.illegal;
   assign bus.hazard_stall  = hazard;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a table of single-instruction captures with
// hand-computed results, then hand-written reset, load-use and priority runs.
module tb_id_ex_stage;

   logic clk;
   logic reset;

   id_ex_stage_if bus ();

   id_ex_stage dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ctl = {valid, reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst}
   // ectl = {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}
   typedef struct packed {
      logic [6:0]  ctl;
      logic [1:0]  aop;
      logic [5:0]  funct;
      logic [4:0]  rs, rt, rd;
      logic [31:0] rs_d, rt_d, imm;
      logic        xm_we;
      logic [4:0]  xm_rd;
      logic [31:0] xm_res;
      logic        mw_we;
      logic [4:0]  mw_rd;
      logic [31:0] mw_res;
      logic [4:0]  ectl;
      logic [4:0]  e_wr;
      logic [2:0]  e_ctrl;
      logic        e_ill;
      logic [31:0] e_a, e_b, e_sd;
   } vec_t;

   localparam int NVEC = 11;
   vec_t vecs [NVEC];

   int n_applied = 0;
   int n_fail    = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_applied++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_fwd();
      bus.exmem_reg_write = 1'b0; bus.exmem_rd = '0; bus.exmem_result = '0;
      bus.memwb_reg_write = 1'b0; bus.memwb_rd = '0; bus.memwb_result = '0;
   endtask

   task automatic drive(input vec_t v);
      {bus.id_valid, bus.id_reg_write, bus.id_mem_read, bus.id_mem_write,
       bus.id_mem_to_reg, bus.id_alu_src, bus.id_reg_dst} = v.ctl;
      bus.id_alu_op  = v.aop;   bus.id_funct   = v.funct;
      bus.id_rs      = v.rs;    bus.id_rt      = v.rt;    bus.id_rd = v.rd;
      bus.id_rs_data = v.rs_d;  bus.id_rt_data = v.rt_d;  bus.id_imm = v.imm;
      bus.exmem_reg_write = v.xm_we; bus.exmem_rd = v.xm_rd; bus.exmem_result = v.xm_res;
      bus.memwb_reg_write = v.mw_we; bus.memwb_rd = v.mw_rd; bus.memwb_result = v.mw_res;
   endtask

   // Drive a simple ID instruction with no bypass activity
   task automatic id_instr(input logic [6:0] ctl, input logic [1:0] aop, input logic [5:0] funct,
                           input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                           input logic [31:0] rs_d, input logic [31:0] rt_d, input logic [31:0] imm);
      vec_t v;
      v = '0;
      v.ctl = ctl; v.aop = aop; v.funct = funct;
      v.rs = rs; v.rt = rt; v.rd = rd; v.rs_d = rs_d; v.rt_d = rt_d; v.imm = imm;
      drive(v);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, " ex_valid"},     {31'd0, bus.ex_valid},      32'd0);
      check({tag, " ex_ctl"},       {27'd0, bus.ex_reg_write, bus.ex_mem_read,
                                     bus.ex_mem_write, bus.ex_mem_to_reg, bus.ex_illegal}, 32'd0);
      check({tag, " write_reg"},    {27'd0, bus.ex_write_reg},  32'd0);
      check({tag, " alu_control"},  {29'd0, bus.alu_control},   32'd2);
      check({tag, " alu_a"},        bus.alu_a,                  32'd0);
      check({tag, " alu_b"},        bus.alu_b,                  32'd0);
      check({tag, " store_data"},   bus.ex_store_data,          32'd0);
      check({tag, " hazard_stall"}, {31'd0, bus.hazard_stall},  32'd0);
   endtask

   initial begin
      // ctl aop funct rs rt rd rs_d rt_d imm | xm_we xm_rd xm_res | mw_we mw_rd mw_res | ectl wr ctrl ill a b sd
      vecs[0]  = '{7'b1100001, 2'b10, 6'h20, 5'd1,  5'd2,  5'd3,  32'd10,     32'd20,     32'd0,
                   1'b0, 5'd0, 32'd0,        1'b0, 5'd0,  32'd0,
                   5'b11000, 5'd3,  3'b010, 1'b0, 32'd10,     32'd20,     32'd20};
      vecs[1]  = '{7'b1100001, 2'b10, 6'h22, 5'd3,  5'd4,  5'd6,  32'd9,      32'h11,     32'd0,
                   1'b1, 5'd4, 32'd5,        1'b1, 5'd4,  32'd7,
                   5'b11000, 5'd6,  3'b110, 1'b0, 32'd9,      32'd5,      32'd5};
      vecs[2]  = '{7'b1100001, 2'b10, 6'h24, 5'd5,  5'd8,  5'd9,  32'd1,      32'hF0,     32'd0,
                   1'b1, 5'd7, 32'h33,       1'b1, 5'd5,  32'hAA,
                   5'b11000, 5'd9,  3'b000, 1'b0, 32'hAA,     32'hF0,     32'hF0};
      vecs[3]  = '{7'b1100001, 2'b10, 6'h25, 5'd0,  5'd9,  5'd10, 32'd0,      32'h12,     32'd0,
                   1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd9, 32'h99,
                   5'b11000, 5'd10, 3'b001, 1'b0, 32'd0,      32'h12,     32'h12};
      vecs[4]  = '{7'b1100010, 2'b00, 6'h00, 5'd11, 5'd10, 5'd0,  32'd100,    32'h55,     32'hFFFF_FFFC,
                   1'b1, 5'd10, 32'h77,      1'b0, 5'd0,  32'd0,
                   5'b11000, 5'd10, 3'b010, 1'b0, 32'd100,    32'hFFFF_FFFC, 32'h77};
      vecs[5]  = '{7'b1001010, 2'b00, 6'h00, 5'd13, 5'd12, 5'd0,  32'h1000,   32'hDEAD,   32'd8,
                   1'b0, 5'd0, 32'd0,        1'b0, 5'd0,  32'd0,
                   5'b10010, 5'd12, 3'b010, 1'b0, 32'h1000,   32'd8,      32'hDEAD};
      vecs[6]  = '{7'b1000000, 2'b01, 6'h00, 5'd14, 5'd15, 5'd0,  32'd3,      32'd3,      32'd0,
                   1'b0, 5'd0, 32'd0,        1'b0, 5'd0,  32'd0,
                   5'b10000, 5'd15, 3'b110, 1'b0, 32'd3,      32'd3,      32'd3};
      vecs[7]  = '{7'b1100001, 2'b10, 6'h2A, 5'd1,  5'd2,  5'd16, 32'd1,      32'd2,      32'd0,
                   1'b0, 5'd0, 32'd0,        1'b0, 5'd0,  32'd0,
                   5'b11000, 5'd16, 3'b010, 1'b1, 32'd1,      32'd2,      32'd2};
      vecs[8]  = '{7'b1100001, 2'b11, 6'h20, 5'd1,  5'd2,  5'd17, 32'd1,      32'd2,      32'd0,
                   1'b0, 5'd0, 32'd0,        1'b0, 5'd0,  32'd0,
                   5'b11000, 5'd17, 3'b010, 1'b1, 32'd1,      32'd2,      32'd2};
      vecs[9]  = '{7'b0100001, 2'b10, 6'h22, 5'd3,  5'd4,  5'd5,  32'd9,      32'd9,      32'd0,
                   1'b0, 5'd0, 32'd0,        1'b0, 5'd0,  32'd0,
                   5'b00000, 5'd0,  3'b010, 1'b0, 32'd0,      32'd0,      32'd0};
      vecs[10] = '{7'b1100001, 2'b10, 6'h20, 5'd20, 5'd21, 5'd22, 32'd1,      32'd2,      32'd0,
                   1'b0, 5'd20, 32'hBAD,     1'b1, 5'd20, 32'h600D,
                   5'b11000, 5'd22, 3'b010, 1'b0, 32'h600D,   32'd2,      32'd2};

      bus.stall = 1'b0;
      bus.flush = 1'b0;
      id_instr(7'd0, 2'b00, 6'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
      clear_fwd();

      // Power-on reset
      reset = 1'b1;
      #12;
      check_reset_state("por");
      $display("reset: ex_valid=%b alu_control=%b", bus.ex_valid, bus.alu_control);
      @(negedge clk);
      reset = 1'b0;

      // Table: one capture per vector
      for (int i = 0; i < NVEC; i++) begin
         drive(vecs[i]);
         tick();
         check($sformatf("v%0d ectl", i), {27'd0, bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read,
                                           bus.ex_mem_write, bus.ex_mem_to_reg}, {27'd0, vecs[i].ectl});
         check($sformatf("v%0d write_reg", i),   {27'd0, bus.ex_write_reg}, {27'd0, vecs[i].e_wr});
         check($sformatf("v%0d alu_control", i), {29'd0, bus.alu_control},  {29'd0, vecs[i].e_ctrl});
         check($sformatf("v%0d illegal", i),     {31'd0, bus.ex_illegal},   {31'd0, vecs[i].e_ill});
         check($sformatf("v%0d alu_a", i),       bus.alu_a,                 vecs[i].e_a);
         check($sformatf("v%0d alu_b", i),       bus.alu_b,                 vecs[i].e_b);
         check($sformatf("v%0d store_data", i),  bus.ex_store_data,         vecs[i].e_sd);
         check($sformatf("v%0d hazard", i),      {31'd0, bus.hazard_stall}, 32'd0);
         $display("vec %0d: valid=%b wr=%0d ctrl=%b ill=%b a=%h b=%h sd=%h", i, bus.ex_valid,
                  bus.ex_write_reg, bus.alu_control, bus.ex_illegal, bus.alu_a, bus.alu_b, bus.ex_store_data);
      end

      // Asynchronous reset mid-stream (last vector left valid state behind)
      reset = 1'b1;
      #2;
      check_reset_state("midreset");
      $display("mid-stream reset: ex_valid=%b alu_a=%h", bus.ex_valid, bus.alu_a);
      @(negedge clk);
      reset = 1'b0;
      clear_fwd();

      // Load-use: lw r2 <- 4(r1), then add r4 = r2 + r3
      id_instr(7'b1110111 & 7'b1110110, 2'b00, 6'd0, 5'd1, 5'd2, 5'd0, 32'd0, 32'd0, 32'd4);
      tick();
      check("lu lw mem_read", {31'd0, bus.ex_mem_read}, 32'd1);
      check("lu lw write_reg", {27'd0, bus.ex_write_reg}, 32'd2);
      id_instr(7'b1100001, 2'b10, 6'h20, 5'd2, 5'd3, 5'd4, 32'd0, 32'd0, 32'd0);
      #1;
      check("lu hazard", {31'd0, bus.hazard_stall}, 32'd1);
      tick();
      check("lu bubble valid", {31'd0, bus.ex_valid}, 32'd0);
      check("lu bubble hazard", {31'd0, bus.hazard_stall}, 32'd0);
      tick();
      check("lu add valid", {31'd0, bus.ex_valid}, 32'd1);
      check("lu add write_reg", {27'd0, bus.ex_write_reg}, 32'd4);
      $display("load-use: add captured wr=%0d after one bubble", bus.ex_write_reg);

      // flush and stall together load a bubble
      bus.flush = 1'b1; bus.stall = 1'b1;
      tick();
      check("flush+stall valid", {31'd0, bus.ex_valid}, 32'd0);
      bus.flush = 1'b0; bus.stall = 1'b0;
      $display("flush+stall: ex_valid=%b", bus.ex_valid);

      // Sustained stall holds state; forwarding still tracks the bypass inputs
      id_instr(7'b1100001, 2'b10, 6'h20, 5'd5, 5'd6, 5'd7, 32'h123, 32'h456, 32'd0);
      tick();
      id_instr(7'b1100001, 2'b10, 6'h22, 5'd8, 5'd9, 5'd10, 32'd0, 32'd0, 32'd0);
      bus.stall = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         check($sformatf("stall c%0d valid", c), {31'd0, bus.ex_valid}, 32'd1);
         check($sformatf("stall c%0d write_reg", c), {27'd0, bus.ex_write_reg}, 32'd7);
         check($sformatf("stall c%0d alu_a", c), bus.alu_a, 32'h123);
         check($sformatf("stall c%0d alu_control", c), {29'd0, bus.alu_control}, 32'd2);
         $display("stall cycle %0d: wr=%0d a=%h", c, bus.ex_write_reg, bus.alu_a);
      end
      bus.exmem_reg_write = 1'b1; bus.exmem_rd = 5'd5; bus.exmem_result = 32'h999;
      #1;
      check("stall fwd alu_a", bus.alu_a, 32'h999);
      bus.stall = 1'b0;
      clear_fwd();

      // hazard with stall holds; then flush beats the hazard
      id_instr(7'b1110110, 2'b00, 6'd0, 5'd1, 5'd2, 5'd0, 32'd0, 32'd0, 32'd4);
      tick();
      id_instr(7'b1100001, 2'b10, 6'h20, 5'd2, 5'd3, 5'd4, 32'd0, 32'd0, 32'd0);
      bus.stall = 1'b1;
      #1;
      check("hz+stall hazard", {31'd0, bus.hazard_stall}, 32'd1);
      tick();
      check("hz+stall hold valid", {31'd0, bus.ex_valid}, 32'd1);
      check("hz+stall hold mem_read", {31'd0, bus.ex_mem_read}, 32'd1);
      check("hz+stall still hazard", {31'd0, bus.hazard_stall}, 32'd1);
      bus.stall = 1'b0; bus.flush = 1'b1;
      tick();
      check("hz+flush valid", {31'd0, bus.ex_valid}, 32'd0);
      check("hz+flush hazard", {31'd0, bus.hazard_stall}, 32'd0);
      bus.flush = 1'b0;
      $display("hazard+stall held, flush cleared: ex_valid=%b hazard=%b", bus.ex_valid, bus.hazard_stall);

      $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_fail);
      $finish;
   end

endmodule
